mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline boundary of the 5-stage RISC-V core.
- Registers the MEM-stage results and waits for variable-latency data-memory load responses.
- Aligns and sign/zero-extends load data (LB/LH/LW/LBU/LHU).
- Presents ALU result, load data, select and destination to the write-back 2:1 multiplexer and register file.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- REG_ADDR_WIDTH, 5, register-file address width.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- MEM_VALID  input  1  MEM stage presents an instruction.
- MEM_READY  output  1  stage can accept; combinational, 1 in IDLE, 0 in WAIT_LOAD.
- MEM_ALU_RESULT  input  DATA_WIDTH  ALU result, or the effective address for loads.
- MEM_RD_ADDR  input  REG_ADDR_WIDTH  destination register.
- MEM_REG_WRITE  input  1  instruction writes rd.
- MEM_IS_LOAD  input  1  instruction is a load.
- MEM_LOAD_TYPE  input  3  load funct3.
- DMEM_RDATA_VALID  input  1  data-memory read data valid (single-cycle pulse).
- DMEM_RDATA  input  DATA_WIDTH  word-aligned read data.
- WB_VALID  output  1  WB outputs are valid this cycle.
- WB_ALU_RESULT  output  DATA_WIDTH  registered ALU result (mux IN1).
- WB_LOAD_DATA  output  DATA_WIDTH  aligned/extended load data (mux IN2).
- WB_MEM_TO_REG  output  1  mux SELECT; 1 = load data.
- WB_RD_ADDR  output  REG_ADDR_WIDTH  destination register.
- WB_REG_WRITE  output  1  qualified register-file write enable.
- LOAD_PENDING  output  1  to hazard unit; equals state==WAIT_LOAD.
- MISALIGNED_LOAD  output  1  one-cycle pulse, coincident with WB_VALID, for a misaligned load.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE.
  - WB_VALID, WB_REG_WRITE, WB_MEM_TO_REG, MISALIGNED_LOAD = 0.
  - WB_ALU_RESULT, WB_LOAD_DATA, WB_RD_ADDR = 0; pending fields cleared.
  - Reset during WAIT_LOAD discards the pending load; a later stray response is ignored.
- States: IDLE, WAIT_LOAD.
- Accept: MEM_VALID & MEM_READY at a rising edge.
- IDLE, accept of a non-load:
  - Next cycle WB_VALID=1, WB_MEM_TO_REG=0, WB_ALU_RESULT/WB_RD_ADDR captured.
  - Latency 1 cycle.
- IDLE, accept of a load with DMEM_RDATA_VALID=1 in the same cycle:
  - Aligned data registered; next cycle WB_VALID=1, WB_MEM_TO_REG=1.
  - Remain IDLE.
- IDLE, accept of a load without response:
  - Capture ALU result (address), rd, reg_write, load type; go to WAIT_LOAD.
  - WB_VALID=0 next cycle.
- WAIT_LOAD:
  - MEM_READY=0; MEM_VALID ignored (upstream holds).
  - On DMEM_RDATA_VALID: register aligned data; next cycle WB_VALID=1, WB_MEM_TO_REG=1; return to IDLE.
  - WB_VALID stays 0 in every wait cycle.
- IDLE, no accept: WB_VALID=0 and WB_REG_WRITE=0; data outputs hold their last values.
- DMEM_RDATA_VALID in IDLE with no load being accepted: ignored.
- Alignment (addr = ALU_RESULT[1:0]):
  - LB/LBU: byte at addr; sign-extended (LB) or zero-extended (LBU).
  - LH/LHU: halfword at addr[1]; sign/zero-extended.
  - LW: full word.
- Misaligned load (LH/LHU with addr[0]=1, or LW with addr!=0):
  - Still waits for the response.
  - On completion: MISALIGNED_LOAD=1, WB_REG_WRITE=0, WB_LOAD_DATA=0.
- Illegal load funct3 (011, 110, 111): WB_REG_WRITE=0, WB_LOAD_DATA=0.
- WB_REG_WRITE = WB_VALID & captured reg_write & (rd!=0) & not misaligned & not illegal.
- A non-load accepted while DMEM_RDATA_VALID=1: response ignored.

Decomposition:
- Shared package riscv_pkg:
  - Load funct3 constants: LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101.
  - DATA_WIDTH/REG_ADDR_WIDTH defaults.
  - State encoding: IDLE=1'b0, WAIT_LOAD=1'b1.
- Sub-module load_data_aligner (combinational):
  - Inputs: DMEM_RDATA, addr[1:0], load type.
  - Outputs: aligned data, misaligned flag, illegal flag.
  - The stage owns the FSM and registers.

Test Plan:
1. ADD result 0x0000_1234, rd=5 accepted in IDLE -> next cycle WB_VALID=1, WB_ALU_RESULT=0x0000_1234, WB_MEM_TO_REG=0, WB_REG_WRITE=1, WB_RD_ADDR=5.
2. LB, addr=0x...03, response 0x80FF_0000 after 3 cycles -> MEM_READY=0 and LOAD_PENDING=1 for 3 cycles; next cycle WB_LOAD_DATA=0xFFFF_FF80, WB_MEM_TO_REG=1, WB_REG_WRITE=1.
3. LHU, addr=0x...02, same-cycle response 0x8001_7FFF -> 1-cycle latency, WB_LOAD_DATA=0x0000_8001, state stays IDLE.
4. LW, addr=0x...01, response 0xDEAD_BEEF -> MISALIGNED_LOAD=1 for one cycle, WB_REG_WRITE=0, WB_LOAD_DATA=0.
5. ADD with rd=0 -> WB_VALID=1, WB_REG_WRITE=0; LW response arriving while IDLE and no load accepted -> outputs unchanged, WB_VALID=0.
6. LW accepted, RST pulsed in WAIT_LOAD, then stray DMEM_RDATA_VALID -> all outputs 0, MEM_READY=1, no WB_VALID.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: default widths, load funct3 codes and the
// MEM/WB stage state encoding.
package riscv_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_REG_ADDR_WIDTH = 5;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } mem_wb_state_e;

  function automatic logic load_type_legal(input logic [2:0] funct3);
    return (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
           (funct3 == LBU) || (funct3 == LHU);
  endfunction

endpackage

// File: rtl/load_data_aligner.sv
// Combinational load alignment: selects the byte/halfword addressed by the
// low address bits and sign/zero-extends it; faulting loads return zero.
module load_data_aligner
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  load_type,
  output logic [31:0] data,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane;
  logic [7:0]  sel_byte;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lanes
    assign byte_lane[gi] = rdata[8*gi +: 8];
  end

  assign half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
  assign sel_byte  = byte_lane[addr];

  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    illegal    = !load_type_legal(load_type);
    case (load_type)
      LB:  data = {{24{sel_byte[7]}}, sel_byte};
      LBU: data = {24'h0, sel_byte};
      LH:  begin
        misaligned = addr[0];
        data       = {{16{half_lane[15]}}, half_lane};
      end
      LHU: begin
        misaligned = addr[0];
        data       = {16'h0, half_lane};
      end
      LW:  begin
        misaligned = (addr != 2'b00);
        data       = rdata;
      end
      default: data = '0;
    endcase
    // Faulting loads must never leak memory contents into the register file path
    if (misaligned || illegal) begin
      data = '0;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline boundary: registers MEM results, stalls for variable-latency
// load responses, and drives the write-back mux and register-file enable.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      MEM_VALID,
  output logic                      MEM_READY,
  input  logic [DATA_WIDTH-1:0]     MEM_ALU_RESULT,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_RD_ADDR,
  input  logic                      MEM_REG_WRITE,
  input  logic                      MEM_IS_LOAD,
  input  logic [2:0]                MEM_LOAD_TYPE,
  input  logic                      DMEM_RDATA_VALID,
  input  logic [DATA_WIDTH-1:0]     DMEM_RDATA,
  output logic                      WB_VALID,
  output logic [DATA_WIDTH-1:0]     WB_ALU_RESULT,
  output logic [DATA_WIDTH-1:0]     WB_LOAD_DATA,
  output logic                      WB_MEM_TO_REG,
  output logic [REG_ADDR_WIDTH-1:0] WB_RD_ADDR,
  output logic                      WB_REG_WRITE,
  output logic                      LOAD_PENDING,
  output logic                      MISALIGNED_LOAD
);

  mem_wb_state_e state_reg, state_next;

  logic [DATA_WIDTH-1:0]     pend_addr_reg, pend_addr_next;
  logic [REG_ADDR_WIDTH-1:0] pend_rd_reg, pend_rd_next;
  logic                      pend_we_reg, pend_we_next;
  logic [2:0]                pend_type_reg, pend_type_next;

  logic                      wb_valid_reg, wb_valid_next;
  logic [DATA_WIDTH-1:0]     wb_alu_reg, wb_alu_next;
  logic [DATA_WIDTH-1:0]     wb_load_reg, wb_load_next;
  logic                      wb_m2r_reg, wb_m2r_next;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_reg, wb_rd_next;
  logic                      wb_we_reg, wb_we_next;
  logic                      mis_reg, mis_next;

  logic                      accept;
  logic [DATA_WIDTH-1:0]     sel_addr;
  logic [REG_ADDR_WIDTH-1:0] sel_rd;
  logic                      sel_we;
  logic [2:0]                sel_type;
  logic [31:0]               align_data;
  logic                      align_mis;
  logic                      align_illegal;

  assign MEM_READY = (state_reg == IDLE);
  assign accept    = MEM_VALID && MEM_READY;

  // While idle the aligner looks at the incoming instruction so a same-cycle
  // response completes without a wait state; otherwise it uses the captured load.
  assign sel_addr = (state_reg == IDLE) ? MEM_ALU_RESULT : pend_addr_reg;
  assign sel_rd   = (state_reg == IDLE) ? MEM_RD_ADDR    : pend_rd_reg;
  assign sel_we   = (state_reg == IDLE) ? MEM_REG_WRITE  : pend_we_reg;
  assign sel_type = (state_reg == IDLE) ? MEM_LOAD_TYPE  : pend_type_reg;

  load_data_aligner u_aligner (
    .rdata      (DMEM_RDATA),
    .addr       (sel_addr[1:0]),
    .load_type  (sel_type),
    .data       (align_data),
    .misaligned (align_mis),
    .illegal    (align_illegal)
  );

  always_comb begin
    state_next     = state_reg;
    pend_addr_next = pend_addr_reg;
    pend_rd_next   = pend_rd_reg;
    pend_we_next   = pend_we_reg;
    pend_type_next = pend_type_reg;
    wb_valid_next  = 1'b0;
    wb_we_next     = 1'b0;
    mis_next       = 1'b0;
    wb_alu_next    = wb_alu_reg;
    wb_load_next   = wb_load_reg;
    wb_m2r_next    = wb_m2r_reg;
    wb_rd_next     = wb_rd_reg;

    case (state_reg)
      IDLE: begin
        if (accept && !MEM_IS_LOAD) begin
          wb_valid_next = 1'b1;
          wb_m2r_next   = 1'b0;
          wb_alu_next   = MEM_ALU_RESULT;
          wb_rd_next    = MEM_RD_ADDR;
          wb_we_next    = MEM_REG_WRITE && (MEM_RD_ADDR != '0);
        end else if (accept && !DMEM_RDATA_VALID) begin
          state_next     = WAIT_LOAD;
          pend_addr_next = MEM_ALU_RESULT;
          pend_rd_next   = MEM_RD_ADDR;
          pend_we_next   = MEM_REG_WRITE;
          pend_type_next = MEM_LOAD_TYPE;
        end
      end
      WAIT_LOAD: begin
        if (DMEM_RDATA_VALID) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Load completion, either same-cycle in IDLE or the awaited response
    if (((state_reg == IDLE) && accept && MEM_IS_LOAD && DMEM_RDATA_VALID) ||
        ((state_reg == WAIT_LOAD) && DMEM_RDATA_VALID)) begin
      wb_valid_next = 1'b1;
      wb_m2r_next   = 1'b1;
      wb_alu_next   = sel_addr;
      wb_rd_next    = sel_rd;
      wb_load_next  = align_data;
      mis_next      = align_mis;
      wb_we_next    = sel_we && (sel_rd != '0) && !align_mis && !align_illegal;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      pend_addr_reg <= '0;
      pend_rd_reg   <= '0;
      pend_we_reg   <= 1'b0;
      pend_type_reg <= '0;
      wb_valid_reg  <= 1'b0;
      wb_alu_reg    <= '0;
      wb_load_reg   <= '0;
      wb_m2r_reg    <= 1'b0;
      wb_rd_reg     <= '0;
      wb_we_reg     <= 1'b0;
      mis_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pend_addr_reg <= pend_addr_next;
      pend_rd_reg   <= pend_rd_next;
      pend_we_reg   <= pend_we_next;
      pend_type_reg <= pend_type_next;
      wb_valid_reg  <= wb_valid_next;
      wb_alu_reg    <= wb_alu_next;
      wb_load_reg   <= wb_load_next;
      wb_m2r_reg    <= wb_m2r_next;
      wb_rd_reg     <= wb_rd_next;
      wb_we_reg     <= wb_we_next;
      mis_reg       <= mis_next;
    end
  end

  assign WB_VALID        = wb_valid_reg;
  assign WB_ALU_RESULT   = wb_alu_reg;
  assign WB_LOAD_DATA    = wb_load_reg;
  assign WB_MEM_TO_REG   = wb_m2r_reg;
  assign WB_RD_ADDR      = wb_rd_reg;
  assign WB_REG_WRITE    = wb_we_reg;
  assign LOAD_PENDING    = (state_reg == WAIT_LOAD);
  assign MISALIGNED_LOAD = mis_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed stimulus pushes expected
// write-back transactions, a negedge monitor pops and compares them.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        MEM_VALID = 1'b0;
  logic        MEM_READY;
  logic [31:0] MEM_ALU_RESULT = '0;
  logic [4:0]  MEM_RD_ADDR = '0;
  logic        MEM_REG_WRITE = 1'b0;
  logic        MEM_IS_LOAD = 1'b0;
  logic [2:0]  MEM_LOAD_TYPE = '0;
  logic        DMEM_RDATA_VALID = 1'b0;
  logic [31:0] DMEM_RDATA = '0;
  logic        WB_VALID;
  logic [31:0] WB_ALU_RESULT;
  logic [31:0] WB_LOAD_DATA;
  logic        WB_MEM_TO_REG;
  logic [4:0]  WB_RD_ADDR;
  logic        WB_REG_WRITE;
  logic        LOAD_PENDING;
  logic        MISALIGNED_LOAD;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] ld;
    logic        m2r;
    logic [4:0]  rd;
    logic        we;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  mem_wb_stage dut (
    .CLK              (CLK),
    .RST              (RST),
    .MEM_VALID        (MEM_VALID),
    .MEM_READY        (MEM_READY),
    .MEM_ALU_RESULT   (MEM_ALU_RESULT),
    .MEM_RD_ADDR      (MEM_RD_ADDR),
    .MEM_REG_WRITE    (MEM_REG_WRITE),
    .MEM_IS_LOAD      (MEM_IS_LOAD),
    .MEM_LOAD_TYPE    (MEM_LOAD_TYPE),
    .DMEM_RDATA_VALID (DMEM_RDATA_VALID),
    .DMEM_RDATA       (DMEM_RDATA),
    .WB_VALID         (WB_VALID),
    .WB_ALU_RESULT    (WB_ALU_RESULT),
    .WB_LOAD_DATA     (WB_LOAD_DATA),
    .WB_MEM_TO_REG    (WB_MEM_TO_REG),
    .WB_RD_ADDR       (WB_RD_ADDR),
    .WB_REG_WRITE     (WB_REG_WRITE),
    .LOAD_PENDING     (LOAD_PENDING),
    .MISALIGNED_LOAD  (MISALIGNED_LOAD)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                       input logic we, input logic ld, input logic [2:0] lt);
    MEM_VALID      = v;
    MEM_ALU_RESULT = alu;
    MEM_RD_ADDR    = rd;
    MEM_REG_WRITE  = we;
    MEM_IS_LOAD    = ld;
    MEM_LOAD_TYPE  = lt;
  endtask

  task automatic respond(input logic v, input logic [31:0] d);
    DMEM_RDATA_VALID = v;
    DMEM_RDATA       = d;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] alu, input logic [31:0] ld, input logic m2r,
                              input logic [4:0] rd, input logic we, input logic mis);
    exp_t e;
    e.alu = alu; e.ld = ld; e.m2r = m2r; e.rd = rd; e.we = we; e.mis = mis;
    return e;
  endfunction

  // Monitor: every presented write-back must match the oldest expectation
  always @(negedge CLK) begin
    if (!RST) begin
      if (WB_VALID) begin
        if (sb.size() == 0) begin
          chk("unexpected_wb_valid", 32'(WB_VALID), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wb_alu_result", WB_ALU_RESULT, e.alu);
          chk("wb_load_data", WB_LOAD_DATA, e.ld);
          chk("wb_mem_to_reg", 32'(WB_MEM_TO_REG), 32'(e.m2r));
          chk("wb_rd_addr", 32'(WB_RD_ADDR), 32'(e.rd));
          chk("wb_reg_write", 32'(WB_REG_WRITE), 32'(e.we));
          chk("misaligned_load", 32'(MISALIGNED_LOAD), 32'(e.mis));
          $display("WB txn alu=0x%08h ld=0x%08h m2r=%0b rd=%0d we=%0b mis=%0b",
                   WB_ALU_RESULT, WB_LOAD_DATA, WB_MEM_TO_REG, WB_RD_ADDR,
                   WB_REG_WRITE, MISALIGNED_LOAD);
        end
      end else if (WB_REG_WRITE || MISALIGNED_LOAD) begin
        chk("strobe_without_valid", {30'd0, WB_REG_WRITE, MISALIGNED_LOAD}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_wb_valid", 32'(WB_VALID), 32'd0);
    chk("rst_wb_alu", WB_ALU_RESULT, 32'd0);
    chk("rst_mem_ready", 32'(MEM_READY), 32'd1);
    chk("rst_load_pending", 32'(LOAD_PENDING), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    step();

    // 1: ADD, rd=5
    drive(1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 3'b000);
    sb.push_back(mk(32'h0000_1234, 32'h0, 1'b0, 5'd5, 1'b1, 1'b0));
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000);

    // 2: LB at ...03, response after 3 wait cycles; upstream holds MEM_VALID
    drive(1'b1, 32'h0000_0103, 5'd7, 1'b1, 1'b1, 3'b000);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("lb_wait_mem_ready", 32'(MEM_READY), 32'd0);
      chk("lb_wait_load_pending", 32'(LOAD_PENDING), 32'd1);
      if (i < 2) step();
    end
    respond(1'b1, 32'h80FF_0000);
    sb.push_back(mk(32'h0000_0103, 32'hFFFF_FF80, 1'b1, 5'd7, 1'b1, 1'b0));
    step();
    respond(1'b0, '0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000);
    chk("lb_done_mem_ready", 32'(MEM_READY), 32'd1);

    // 3: LHU at ...02, same-cycle response
    drive(1'b1, 32'h0000_0202, 5'd8, 1'b1, 1'b1, 3'b101);
    respond(1'b1, 32'h8001_7FFF);
    sb.push_back(mk(32'h0000_0202, 32'h0000_8001, 1'b1, 5'd8, 1'b1, 1'b0));
    step();
    chk("lhu_stays_idle", 32'(LOAD_PENDING), 32'd0);

    // LH at ...00, same-cycle response: sign-extended low half
    drive(1'b1, 32'h0000_0200, 5'd10, 1'b1, 1'b1, 3'b001);
    respond(1'b1, 32'h1234_F00D);
    sb.push_back(mk(32'h0000_0200, 32'hFFFF_F00D, 1'b1, 5'd10, 1'b1, 1'b0));
    step();

    // LBU at ...01, same-cycle response: zero-extended
    drive(1'b1, 32'h0000_0201, 5'd11, 1'b1, 1'b1, 3'b100);
    respond(1'b1, 32'h0000_9A00);
    sb.push_back(mk(32'h0000_0201, 32'h0000_009A, 1'b1, 5'd11, 1'b1, 1'b0));
    step();
    respond(1'b0, '0);

    // 4: LW at ...01 (misaligned), response one cycle later
    drive(1'b1, 32'h0000_0301, 5'd9, 1'b1, 1'b1, 3'b010);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000);
    respond(1'b1, 32'hDEAD_BEEF);
    sb.push_back(mk(32'h0000_0301, 32'h0, 1'b1, 5'd9, 1'b0, 1'b1));
    step();
    respond(1'b0, '0);

    // Illegal funct3 011 with same-cycle response
    drive(1'b1, 32'h0000_0400, 5'd12, 1'b1, 1'b1, 3'b011);
    respond(1'b1, 32'h7777_7777);
    sb.push_back(mk(32'h0000_0400, 32'h0, 1'b1, 5'd12, 1'b0, 1'b0));
    step();
    respond(1'b0, '0);

    // 5: ADD with rd=0, then a stray response while idle
    drive(1'b1, 32'h0000_0055, 5'd0, 1'b1, 1'b0, 3'b000);
    sb.push_back(mk(32'h0000_0055, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0));
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000);
    respond(1'b1, 32'hCAFE_BABE);
    step();
    respond(1'b0, '0);
    step();
    chk("idle_hold_alu", WB_ALU_RESULT, 32'h0000_0055);
    chk("idle_hold_load", WB_LOAD_DATA, 32'h0);
    chk("idle_hold_m2r", 32'(WB_MEM_TO_REG), 32'd0);
    chk("idle_wb_valid", 32'(WB_VALID), 32'd0);

    // 6: LW pending, asynchronous reset mid-wait, then stray response
    drive(1'b1, 32'h0000_0500, 5'd3, 1'b1, 1'b1, 3'b010);
    step();
    chk("rst6_pending_before", 32'(LOAD_PENDING), 32'd1);
    #2;
    RST = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000);
    #1;
    chk("rst6_mem_ready", 32'(MEM_READY), 32'd1);
    chk("rst6_load_pending", 32'(LOAD_PENDING), 32'd0);
    chk("rst6_wb_alu", WB_ALU_RESULT, 32'h0);
    chk("rst6_wb_valid", 32'(WB_VALID), 32'd0);
    #2;
    RST = 1'b0;
    respond(1'b1, 32'h1111_2222);
    step();
    respond(1'b0, '0);
    step();
    chk("stray_wb_valid", 32'(WB_VALID), 32'd0);
    chk("stray_load_data", WB_LOAD_DATA, 32'h0);
    chk("stray_load_pending", 32'(LOAD_PENDING), 32'd0);

    repeat (3) step();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
